// File: rtl/uart_lb_pkg.sv
// -----------------------------------------------------------------------------
// uart_lb_pkg
// Shared types and constants for the buffered UART loopback engine.
//   rx_state_t  : receive-handshake FSM states
//   tx_state_t  : transmit-handshake FSM states
//   DROP_CNT_W  : width of the saturating dropped-byte counter
//   addr_width(): FIFO address width for a given (power-of-two) depth
// -----------------------------------------------------------------------------
package uart_lb_pkg;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_CLR  = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int DROP_CNT_W = 8;

    // Address width of a FIFO of 'depth' entries; never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding received characters until the transmitter is free.
// Pointers carry one extra wrap bit; full/empty come from comparing them.
// The head entry is read asynchronously so the consumer can register it in
// the same cycle it pops.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (empties the FIFO)
//   push   in   write din (accepted if not full, or full with a pop)
//   pop    in   remove head entry (ignored when empty)
//   din    in   DATA_W  write data
//   dout   out  DATA_W  head entry
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
//   level  out  ADDR_W+1  current occupancy, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_lb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [addr_width(DEPTH):0]    level
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   rd_ptr_reg;
    logic [ADDR_W:0]   level_reg;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    // A push into a full FIFO is still taken when the head leaves this cycle:
    // the freed slot is the very one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout  = mem[rd_ptr_reg[ADDR_W-1:0]];
    assign level = level_reg;

    // Storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + (ADDR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + (ADDR_W+1)'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + (ADDR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (ADDR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_loopback.sv
// -----------------------------------------------------------------------------
// uart_fifo_loopback
// Buffered echo path between the UART receiver (rdy / rdy_clr / data) and the
// UART transmitter (start / busy). Received characters are queued in a FIFO so
// bursts arriving while the transmitter is busy are not lost until the FIFO
// fills; further characters are dropped and (optionally) counted.
//
// Build option:
//   UART_LB_STATS_EN  defined   -> overflow flag and drop counter are built
//                     undefined -> overflow and drop_count are constant 0
//
// Ports:
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   enable      in   1 = echo, 0 = acknowledge and discard received bytes
//   rx_rdy      in   receiver holds a valid byte (level)
//   rx_data     in   DATA_W received byte
//   rx_rdy_clr  out  clear request back to the receiver
//   tx_busy     in   transmitter busy
//   tx_start    out  one-cycle start pulse
//   tx_data     out  DATA_W byte being transmitted
//   fifo_level  out  $clog2(DEPTH)+1 FIFO occupancy
//   overflow    out  sticky, set on first dropped byte
//   drop_count  out  8 saturating count of dropped bytes
// -----------------------------------------------------------------------------
module uart_fifo_loopback
    import uart_lb_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rx_rdy,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     rx_rdy_clr,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    // The timer counts cycles since tx_start; the start cycle itself is 1.
    localparam int             TIMER_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(BUSY_TIMEOUT - 1);

    rx_state_t            rx_state_reg;
    tx_state_t            tx_state_reg;
    logic                 rx_rdy_clr_reg;
    logic                 tx_start_reg;
    logic [DATA_W-1:0]    tx_data_reg;
    logic [TIMER_W-1:0]   timer_reg;

    logic                 rx_capture;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_W-1:0]    fifo_dout;

    // A byte is captured exactly once: only in RX_IDLE, which is left at once.
    assign rx_capture = (rx_state_reg == RX_IDLE) && rx_rdy;
    assign fifo_push  = rx_capture && enable;
    assign fifo_pop   = (tx_state_reg == TX_IDLE) && !fifo_empty;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ------------------------------------------------------------------
    // Receive handshake: capture, then hold rdy_clr until rdy drops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg   <= RX_IDLE;
            rx_rdy_clr_reg <= 1'b0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_rdy) begin
                        rx_state_reg   <= RX_CLR;
                        rx_rdy_clr_reg <= 1'b1;
                    end
                end
                RX_CLR: begin
                    if (!rx_rdy) begin
                        rx_state_reg   <= RX_IDLE;
                        rx_rdy_clr_reg <= 1'b0;
                    end
                end
                default: begin
                    rx_state_reg   <= RX_IDLE;
                    rx_rdy_clr_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit handshake. tx_data is loaded on pop and held until the next
    // pop, so it stays stable for the whole transmission.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            timer_reg    <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_data_reg  <= fifo_dout;
                        tx_start_reg <= 1'b1;
                        tx_state_reg <= TX_START;
                    end
                end
                TX_START: begin
                    timer_reg    <= TIMER_W'(1);
                    tx_state_reg <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (tx_busy) begin
                        tx_state_reg <= TX_WAIT_DONE;
                    end else if (timer_reg >= TIMER_MAX) begin
                        // Transmitter never acknowledged; treat byte as sent.
                        tx_state_reg <= TX_IDLE;
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                TX_WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_state_reg <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_reg <= TX_IDLE;
                end
            endcase
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_reg;
    assign tx_start   = tx_start_reg;
    assign tx_data    = tx_data_reg;

    // ------------------------------------------------------------------
    // Drop statistics. A drop is an enabled capture the FIFO cannot take.
    // ------------------------------------------------------------------
`ifdef UART_LB_STATS_EN
    logic                  push_drop;
    logic                  overflow_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    assign push_drop = fifo_push && fifo_full && !fifo_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (push_drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != {DROP_CNT_W{1'b1}}) begin
                drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
            end
        end
    end

    assign overflow   = overflow_reg;
    assign drop_count = drop_cnt_reg;
`else
    assign overflow   = 1'b0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_loopback
// Directed bench: a receiver model drives rx_rdy/rx_data, a transmitter model
// answers tx_start with tx_busy, and every echoed byte is checked in order
// against a scoreboard filled when the byte is offered.
// -----------------------------------------------------------------------------
module tb_uart_fifo_loopback;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 8;

`ifdef UART_LB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   rx_rdy;
    logic [DATA_W-1:0]      rx_data;
    logic                   rx_rdy_clr;
    logic                   tx_busy;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic [7:0]             drop_count;

    uart_fifo_loopback #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          starts = 0;
    int          last_start = 0;
    int          prev_start = 0;
    int          sent_cyc = 0;
    int          busy_mode = 0;   // 0 auto pulse, 1 hold high, 2 never busy
    int          busy_len = 2;
    int          auto_cnt = 0;
    logic        prev_tx_start = 1'b0;
    logic [7:0]  sb [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises the cycle after tx_start for busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            case (busy_mode)
                1: tx_busy = 1'b1;
                2: tx_busy = 1'b0;
                default: begin
                    if (auto_cnt > 0) begin
                        tx_busy = 1'b1;
                        auto_cnt--;
                    end else begin
                        tx_busy = 1'b0;
                    end
                    if (tx_start === 1'b1) auto_cnt = busy_len;
                end
            endcase
        end
    end

    // Output monitor: every start pulse pops the scoreboard.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                check("start_pulse_width", {31'd0, prev_tx_start}, 32'd0);
                starts++;
                prev_start = last_start;
                last_start = cyc;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_start observed=0x%0h expected=no_start", tx_data);
                end
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("echo_data", {24'd0, tx_data}, {24'd0, exp_b});
                    $display("echo byte=0x%02h cycle=%0d", tx_data, cyc);
                end
            end
            prev_tx_start = tx_start;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit expect_echo, input int hold);
        rx_data  = d;
        rx_rdy   = 1'b1;
        sent_cyc = cyc;
        if (expect_echo) sb.push_back(d);
        @(posedge clk); #1;
        check("clr_rise", {31'd0, rx_rdy_clr}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("clr_hold", {31'd0, rx_rdy_clr}, 32'd1);
        end
        rx_rdy = 1'b0;
        @(posedge clk); #1;
        check("clr_fall", {31'd0, rx_rdy_clr}, 32'd0);
        $display("rx byte=0x%02h echo=%0d cycle=%0d", d, expect_echo, sent_cyc);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_drained"}, sb.size(), 32'd0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_rdy_clr"}, {31'd0, rx_rdy_clr}, 32'd0);
        check({tag, "_tx_start"},   {31'd0, tx_start},   32'd0);
        check({tag, "_tx_data"},    {24'd0, tx_data},    32'd0);
        check({tag, "_fifo_level"}, {27'd0, fifo_level}, 32'd0);
        check({tag, "_overflow"},   {31'd0, overflow},   32'd0);
        check({tag, "_drop_count"}, {24'd0, drop_count}, 32'd0);
    endtask

    initial begin
        int t0;
        int s0;
        rst_n   = 1'b0;
        enable  = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte, latency from rx_rdy sample to tx_start.
        send_byte(8'h41, 1'b1, 2);
        t0 = sent_cyc;
        drain("single", 50);
        check("latency", last_start - t0, 32'd2);
        check("single_starts", starts, 32'd1);

        // Back-to-back bytes with a one-cycle busy pulse: minimum spacing.
        busy_len = 1;
        send_byte(8'h31, 1'b1, 0);
        send_byte(8'h32, 1'b1, 0);
        drain("spacing", 50);
        check("start_spacing", last_start - prev_start, 32'd4);
        busy_len = 2;

        // Five bytes queued behind a stalled transmission.
        busy_mode = 1;
        send_byte(8'h00, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 0);
        check("burst_level", {27'd0, fifo_level}, 32'd5);
        busy_mode = 0;
        drain("burst", 200);
        check("burst_level_empty", {27'd0, fifo_level}, 32'd0);

        // Overflow: 18 bytes into 16 entries, last two dropped.
        busy_mode = 1;
        send_byte(8'hA0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) send_byte(8'(8'h10 + i), (i < 16), 0);
        check("full_level", {27'd0, fifo_level}, 32'd16);
        check("overflow_flag", {31'd0, overflow}, STATS);
        check("drop_count", {24'd0, drop_count}, STATS * 2);

        // Release the transmitter so its pop coincides with the next push.
        busy_mode = 0;
        @(posedge clk); #1;
        send_byte(8'hEE, 1'b1, 0);
        check("pushpop_level", {27'd0, fifo_level}, 32'd16);
        check("pushpop_drop_count", {24'd0, drop_count}, STATS * 2);
        drain("overflow", 400);
        check("overflow_level_empty", {27'd0, fifo_level}, 32'd0);

        // Busy never rises: abandon after timeout, next byte follows.
        busy_mode = 2;
        send_byte(8'h61, 1'b1, 0);
        send_byte(8'h62, 1'b1, 0);
        drain("timeout", 100);
        check("timeout_spacing", last_start - prev_start, BUSY_TIMEOUT + 1);

        // Disabled: handshake completes, nothing queued or sent.
        busy_mode = 0;
        enable = 1'b0;
        s0 = starts;
        send_byte(8'h55, 1'b0, 1);
        repeat (6) @(posedge clk);
        #1;
        check("disabled_level", {27'd0, fifo_level}, 32'd0);
        check("disabled_starts", starts, s0);
        enable = 1'b1;

        // Reset mid-transmit with bytes still queued.
        busy_mode = 1;
        send_byte(8'h71, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'h72, 1'b1, 0);
        send_byte(8'h73, 1'b1, 0);
        check("pre_reset_level", {27'd0, fifo_level}, 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        busy_mode = 0;
        @(posedge clk); #1;
        send_byte(8'h74, 1'b1, 0);
        drain("post_reset", 50);
        check("post_reset_level", {27'd0, fifo_level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_loopback.md
# uart_fifo_loopback

Parametrised, buffered loopback engine between the existing UART receiver (rdy/rdy_clr/data handshake) and UART transmitter (tx_start/tx_busy handshake). It replaces the unbuffered single-byte echo path. An internal FIFO absorbs back-to-back received bytes while the transmitter is busy, so no byte is lost until the FIFO is full. It sits in the UART top level, clocked by the system clock.

## Interface
Parameters:
- DATA_W, 8, character width in bits (5..9).
- DEPTH, 16, FIFO entries; power of two, 2..256.
- BUSY_TIMEOUT, 4096, cycles to wait for tx_busy to rise after tx_start before abandoning the wait.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; one clock.
- enable  in  1  1 = echo; 0 = acknowledge and discard received bytes.
- rx_rdy  in  1  receiver holds byte valid; level, stays high until cleared.
- rx_data  in  DATA_W  received byte, valid while rx_rdy=1.
- rx_rdy_clr  out  1  clear request to receiver.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  one-cycle start pulse to transmitter.
- tx_data  out  DATA_W  byte to transmit; stable from tx_start until tx_busy falls.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set on first dropped byte.
- drop_count  out  8  saturating count of dropped bytes.

## Operation
- Reset (rst_n=0 at a clk edge): rx_rdy_clr=0, tx_start=0, tx_data=0, fifo_level=0, overflow=0, drop_count=0. FIFO is emptied and both FSMs go to idle. Reset mid-transfer abandons the byte; there is no recovery of FIFO contents.
- RX FSM, states RX_IDLE and RX_CLR:
  - RX_IDLE: on rx_rdy=1, capture rx_data and go to RX_CLR.
  - Capture means push if enable=1; discard if enable=0.
  - RX_CLR: rx_rdy_clr=1. Return to RX_IDLE when rx_rdy is sampled 0.
  - Each rx_rdy assertion is captured exactly once.
- Push rule: accepted if !full, or if full and a pop occurs in the same cycle. Otherwise the byte is dropped: overflow set, drop_count incremented, saturating at 255.
- TX FSM, states TX_IDLE, TX_START, TX_WAIT_BUSY and TX_WAIT_DONE:
  - TX_IDLE: if FIFO is not empty, pop the head into tx_data and go to TX_START.
  - TX_START: tx_start=1 for exactly one cycle, then go to TX_WAIT_BUSY.
  - TX_WAIT_BUSY: go to TX_WAIT_DONE on tx_busy=1. Go to TX_IDLE if BUSY_TIMEOUT cycles elapse; the byte is counted as sent.
  - TX_WAIT_DONE: go to TX_IDLE on tx_busy=0.
- enable=0 never aborts an in-flight transmission. The FIFO keeps draining.
- fifo_level changes as follows: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Pointers are ADDR_W+1 bits with natural wrap. Full and empty are decided by pointer MSB compare.

## Timing
- rx_rdy sampled high in cycle N: FIFO written at the end of N. rx_rdy_clr is high from N+1.
- Empty FIFO with idle TX, byte pushed in cycle N: pop and tx_data load at the end of N+1. tx_start is high in cycle N+2. Minimum latency is 2 cycles.
- Minimum spacing between consecutive tx_start pulses is 4 cycles, which applies when tx_busy pulses for one cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- UART_LB_STATS_EN
  - Defined: overflow and drop_count are implemented as above.
  - Undefined: both outputs are tied to 0, and no counter or flag registers are built. Drop behaviour on full is unchanged.

## Structure
- Package uart_lb_pkg holds:
  - RX and TX state enums and their encodings.
  - A DROP_CNT_W=8 constant.
  - A helper function for the address width.
- Sub-module uart_sync_fifo, parameterised by DATA_W and DEPTH. It provides push, pop, dout, full, empty and level. It is instantiated once; both FSMs stay in the top.

## Test plan
- Single byte 0x41 with tx_busy low→high→low after tx_start: one tx_start pulse, tx_data=0x41, two cycles after rx_rdy is sampled. rx_rdy_clr stays high until rx_rdy drops.
- Five bytes 0x01..0x05 while tx_busy is held high: fifo_level reaches 5. On release, bytes are echoed in order 0x01..0x05. fifo_level returns to 0.
- DEPTH=16, with 18 bytes received and TX stalled: fifo_level=16, overflow=1, drop_count=2. The first 16 bytes are echoed unchanged.
- Push into a full FIFO in the same cycle as a pop: byte accepted, fifo_level stays 16, drop_count unchanged.
- tx_busy never rises, with BUSY_TIMEOUT=8: TX returns to idle 8 cycles after tx_start, and the next byte is started.
- enable=0 while 0x55 is received: rx_rdy_clr handshake completes and nothing is pushed. Assert rst_n=0 mid-transmit: all outputs reset next edge and FIFO is empty.
